// File: rtl/decode_pkg.sv
// RV32I decode stage shared types: opcodes, immediate formats and
// the per-instruction control bundle produced by decode_ctrl().
package decode_pkg;

    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        imm_fmt_e   fmt;
        logic       rs1_used;
        logic       rs2_used;
        logic       rd_wr;
        logic       illegal;
    } decode_bundle_t;

    // Every legal opcode ends in 2'b11, so the default arm also
    // catches compressed/reserved encodings.
    function automatic decode_bundle_t decode_ctrl(input logic [31:0] instr);
        decode_bundle_t d;
        d.opcode   = instr[6:0];
        d.funct3   = instr[14:12];
        d.funct7   = instr[31:25];
        d.fmt      = IMM_R;
        d.rs1_used = 1'b0;
        d.rs2_used = 1'b0;
        d.rd_wr    = 1'b0;
        d.illegal  = 1'b0;
        case (instr[6:0])
            LUI, AUIPC: begin
                d.fmt   = IMM_U;
                d.rd_wr = 1'b1;
            end
            JAL: begin
                d.fmt   = IMM_J;
                d.rd_wr = 1'b1;
            end
            JALR, LOAD, OP_IMM: begin
                d.fmt      = IMM_I;
                d.rs1_used = 1'b1;
                d.rd_wr    = 1'b1;
            end
            BRANCH: begin
                d.fmt      = IMM_B;
                d.rs1_used = 1'b1;
                d.rs2_used = 1'b1;
            end
            STORE: begin
                d.fmt      = IMM_S;
                d.rs1_used = 1'b1;
                d.rs2_used = 1'b1;
            end
            OP: begin
                d.rs1_used = 1'b1;
                d.rs2_used = 1'b1;
                d.rd_wr    = 1'b1;
            end
            MISC_MEM: d.fmt = IMM_R;
            SYSTEM:   d.fmt = IMM_I;
            default:  d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational RV32I immediate generator: instruction fields plus
// format select to a sign-extended XLEN immediate.
module decode_imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        unique case (fmt)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with scoreboard hazard stall and one-entry skid-free
// output register. Define DECODE_WB_BYPASS_EN to forward writeback data.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int NREGS  = 2**REG_AW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_if_valid,
    output logic              o_if_ready,
    input  logic [XLEN-1:0]   i_if_instr,
    input  logic [XLEN-1:0]   i_if_pc,
    output logic              o_du_valid,
    input  logic              i_ex_ready,
    output logic [XLEN-1:0]   o_pc,
    output logic [6:0]        o_opcode,
    output logic [2:0]        o_funct3,
    output logic [6:0]        o_funct7,
    output logic [XLEN-1:0]   o_immediate,
    output logic [XLEN-1:0]   o_rs1_rdata,
    output logic [XLEN-1:0]   o_rs2_rdata,
    output logic [REG_AW-1:0] o_rd_waddr,
    output logic              o_rd_wen,
    output logic              o_illegal,
    output logic [REG_AW-1:0] o_rf_rs1_raddr,
    input  logic [XLEN-1:0]   i_rf_rs1_rdata,
    output logic [REG_AW-1:0] o_rf_rs2_raddr,
    input  logic [XLEN-1:0]   i_rf_rs2_rdata,
    input  logic              i_wb_valid,
    input  logic [REG_AW-1:0] i_wb_addr,
    input  logic [XLEN-1:0]   i_wb_data,
    input  logic              i_flush
);

    logic [REG_AW-1:0] rs1, rs2, rd;
    decode_bundle_t    ctl;
    logic [XLEN-1:0]   imm, rs1_val, rs2_val;
    logic [NREGS-1:0]  sb, sb_rs, sb_set, sb_clr;
    logic              rd_wen, held_wr, hazard, accept, issue;
    logic              rs1_busy, rs2_busy, rd_busy;

    assign rs1 = i_if_instr[15 +: REG_AW];
    assign rs2 = i_if_instr[20 +: REG_AW];
    assign rd  = i_if_instr[7 +: REG_AW];
    assign ctl = decode_ctrl(i_if_instr[31:0]);

    assign rd_wen         = ctl.rd_wr && (rd != '0);
    assign o_rf_rs1_raddr = rs1;
    assign o_rf_rs2_raddr = rs2;

    decode_imm_gen #(.XLEN(XLEN)) u_imm (
        .instr (i_if_instr[31:7]),
        .fmt   (ctl.fmt),
        .imm   (imm)
    );

    assign sb_clr = i_wb_valid ? (NREGS'(1) << i_wb_addr) : '0;

`ifdef DECODE_WB_BYPASS_EN
    // A register being written back this cycle is already resolved.
    assign sb_rs   = sb & ~sb_clr;
    assign rs1_val = (rs1 == '0) ? '0 :
                     (i_wb_valid && i_wb_addr == rs1) ? i_wb_data :
                     i_rf_rs1_rdata;
    assign rs2_val = (rs2 == '0) ? '0 :
                     (i_wb_valid && i_wb_addr == rs2) ? i_wb_data :
                     i_rf_rs2_rdata;
`else
    logic wb_data_unused;
    assign wb_data_unused = ^i_wb_data;
    assign sb_rs   = sb;
    assign rs1_val = (rs1 == '0) ? '0 : i_rf_rs1_rdata;
    assign rs2_val = (rs2 == '0) ? '0 : i_rf_rs2_rdata;
`endif

    // The held bundle's rd counts as pending until it issues.
    assign held_wr  = o_du_valid && o_rd_wen;
    assign rs1_busy = ctl.rs1_used && (rs1 != '0) &&
                      (sb_rs[rs1] || (held_wr && o_rd_waddr == rs1));
    assign rs2_busy = ctl.rs2_used && (rs2 != '0) &&
                      (sb_rs[rs2] || (held_wr && o_rd_waddr == rs2));
    assign rd_busy  = rd_wen &&
                      (sb[rd] || (held_wr && o_rd_waddr == rd));

    assign hazard     = i_if_valid && (rs1_busy || rs2_busy || rd_busy);
    assign o_if_ready = (!o_du_valid || i_ex_ready) && !hazard && !i_flush;
    assign accept     = i_if_valid && o_if_ready;
    assign issue      = held_wr && i_ex_ready && !i_flush;
    assign sb_set     = issue ? (NREGS'(1) << o_rd_waddr) : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sb <= '0;
        end else begin
            sb <= ((sb & ~sb_clr) | sb_set) & ~NREGS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_du_valid  <= 1'b0;
            o_pc        <= '0;
            o_opcode    <= '0;
            o_funct3    <= '0;
            o_funct7    <= '0;
            o_immediate <= '0;
            o_rs1_rdata <= '0;
            o_rs2_rdata <= '0;
            o_rd_waddr  <= '0;
            o_rd_wen    <= 1'b0;
            o_illegal   <= 1'b0;
        end else if (accept) begin
            o_du_valid  <= 1'b1;
            o_pc        <= i_if_pc;
            o_opcode    <= ctl.opcode;
            o_funct3    <= ctl.funct3;
            o_funct7    <= ctl.funct7;
            o_immediate <= imm;
            o_rs1_rdata <= rs1_val;
            o_rs2_rdata <= rs2_val;
            o_rd_waddr  <= rd;
            o_rd_wen    <= rd_wen;
            o_illegal   <= ctl.illegal;
        end else if (i_flush || i_ex_ready) begin
            o_du_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: issue, hazards, backpressure,
// flush, reset, illegal and immediate formats.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_valid, if_ready;
    logic [31:0] instr, if_pc;
    logic        du_valid, ex_ready;
    logic [31:0] pc, imm, rs1_rdata, rs2_rdata;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd_waddr, ra1, ra2, wb_addr;
    logic        rd_wen, illegal, wb_valid, flush;
    logic [31:0] rd1, rd2, wb_data;
    logic [31:0] rf [32];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    always @(posedge clk)
        if (wb_valid) rf[wb_addr] <= wb_data;

    decode_stage dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_if_valid     (if_valid),
        .o_if_ready     (if_ready),
        .i_if_instr     (instr),
        .i_if_pc        (if_pc),
        .o_du_valid     (du_valid),
        .i_ex_ready     (ex_ready),
        .o_pc           (pc),
        .o_opcode       (opcode),
        .o_funct3       (funct3),
        .o_funct7       (funct7),
        .o_immediate    (imm),
        .o_rs1_rdata    (rs1_rdata),
        .o_rs2_rdata    (rs2_rdata),
        .o_rd_waddr     (rd_waddr),
        .o_rd_wen       (rd_wen),
        .o_illegal      (illegal),
        .o_rf_rs1_raddr (ra1),
        .i_rf_rs1_rdata (rd1),
        .o_rf_rs2_raddr (ra2),
        .i_rf_rs2_rdata (rd2),
        .i_wb_valid     (wb_valid),
        .i_wb_addr      (wb_addr),
        .i_wb_data      (wb_data),
        .i_flush        (flush)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] ins, input logic [31:0] a);
        if_valid = 1'b1;
        instr    = ins;
        if_pc    = a;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + i;
        rf[0] = 32'hDEAD_BEEF;
        rstn = 1'b0; if_valid = 1'b0; instr = '0; if_pc = '0;
        ex_ready = 1'b1; wb_valid = 1'b0; wb_addr = '0;
        wb_data = '0; flush = 1'b0;
        step; step;
        rstn = 1'b1;
        #1;
        chk("rst_valid", du_valid, 0);
        chk("rst_ready", if_ready, 1);
        chk("rst_imm", imm, 0);

        // ADDI x5,x0,-1
        put(32'hFFF00293, 32'h100);
        chk("addi_ready", if_ready, 1);
        step;
        chk("addi_valid", du_valid, 1);
        chk("addi_imm", imm, 32'hFFFF_FFFF);
        chk("addi_rd", rd_waddr, 5);
        chk("addi_wen", rd_wen, 1);
        chk("addi_pc", pc, 32'h100);
        chk("addi_opc", opcode, 7'h13);
        chk("addi_x0", rs1_rdata, 0);

        // ADD x6,x5,x5 stalls on x5
        put(32'h00528333, 32'h104);
        chk("raw_held", if_ready, 0);
        step;
        chk("raw_drain", du_valid, 0);
        chk("raw_sb", if_ready, 0);
        step;
        chk("raw_sb2", if_ready, 0);
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        #1;
`ifdef DECODE_WB_BYPASS_EN
        chk("raw_wb_ready", if_ready, 1);
        step;
        wb_valid = 1'b0;
`else
        chk("raw_wb_ready", if_ready, 0);
        step;
        wb_valid = 1'b0;
        #1;
        chk("raw_after_wb", if_ready, 1);
        step;
`endif
        chk("add_valid", du_valid, 1);
        chk("add_rs1", rs1_rdata, 32'h1234);
        chk("add_rs2", rs2_rdata, 32'h1234);
        chk("add_rd", rd_waddr, 6);
        chk("add_imm", imm, 0);
        chk("add_pc", pc, 32'h104);
        if_valid = 1'b0;
        step;

        // Backpressure: ADDI x7,x0,5 held, ADDI x8,x0,3 waiting
        ex_ready = 1'b0;
        put(32'h00500393, 32'h200);
        step;
        put(32'h00300413, 32'h204);
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", if_ready, 0);
            chk("bp_valid", du_valid, 1);
            chk("bp_pc", pc, 32'h200);
            chk("bp_imm", imm, 5);
            step;
        end
        ex_ready = 1'b1;
        #1;
        chk("bp_release", if_ready, 1);
        step;
        chk("bp_next_pc", pc, 32'h204);
        chk("bp_next_imm", imm, 3);
        chk("bp_next_rd", rd_waddr, 8);

        // Flush the held x8 bundle
        ex_ready = 1'b0; if_valid = 1'b0; flush = 1'b1;
        #1;
        chk("flush_ready", if_ready, 0);
        step;
        flush = 1'b0;
        chk("flush_valid", du_valid, 0);
        ex_ready = 1'b1;
        put(32'h00040493, 32'h208);
        chk("flush_sb8", if_ready, 1);
        put(32'h00038513, 32'h20c);
        chk("flush_sb7", if_ready, 0);

        // Illegal instruction then reset mid-stream
        put(32'h0000_0000, 32'h300);
        chk("ill_ready", if_ready, 1);
        step;
        chk("ill_valid", du_valid, 1);
        chk("ill_flag", illegal, 1);
        chk("ill_wen", rd_wen, 0);
        chk("ill_pc", pc, 32'h300);
        rstn = 1'b0; if_valid = 1'b0;
        step;
        rstn = 1'b1;
        chk("mrst_valid", du_valid, 0);
        chk("mrst_pc", pc, 0);
        chk("mrst_ill", illegal, 0);
        chk("mrst_rd", rd_waddr, 0);
        put(32'h00038513, 32'h20c);
        chk("mrst_sb", if_ready, 1);
        step;
        chk("x10_rs1", rs1_rdata, 32'hA000_0007);
        chk("x10_rd", rd_waddr, 10);

        // BEQ x0,x0,-4
        put(32'hFE000EE3, 32'h400);
        chk("beq_ready", if_ready, 1);
        step;
        chk("beq_imm", imm, 32'hFFFF_FFFC);
        chk("beq_wen", rd_wen, 0);
        chk("beq_ill", illegal, 0);
        chk("beq_opc", opcode, 7'h63);

        // LUI x11,0x12345
        put(32'h123455B7, 32'h404);
        step;
        chk("lui_imm", imm, 32'h1234_5000);
        chk("lui_rd", rd_waddr, 11);
        chk("lui_wen", rd_wen, 1);

        // SW x5,-8(x0)
        put(32'hFE502C23, 32'h408);
        step;
        chk("sw_imm", imm, 32'hFFFF_FFF8);
        chk("sw_rs2", rs2_rdata, 32'h1234);
        chk("sw_f3", funct3, 2);
        chk("sw_f7", funct7, 7'h7F);
        chk("sw_wen", rd_wen, 0);

        // JAL x1,+8
        put(32'h008000EF, 32'h40c);
        step;
        chk("jal_imm", imm, 8);
        chk("jal_rd", rd_waddr, 1);
        chk("jal_wen", rd_wen, 1);
        chk("jal_pc", pc, 32'h40c);
        if_valid = 1'b0;
        step;
        chk("idle_valid", du_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Parametrised RV32I decode stage between instruction fetch and execute. It uses full valid/ready handshakes on both sides and a one-entry output register that holds under backpressure. It decodes all base formats and generates immediates, reads an external register file, and tracks pending writes in a scoreboard to stall RAW/WAW hazards. It also supports a pipeline flush and flags illegal opcodes.

Parameters:
XLEN, 32, data/instruction/PC width
REG_AW, 5, register address width (4 gives RV32E, 16 regs)
NREGS, 2**REG_AW, number of architectural registers tracked by the scoreboard

Ports:
clk  in  1  clock
rstn  in  1  reset
i_if_valid  in  1  fetch instruction valid
o_if_ready  out  1  decode can accept
i_if_instr  in  XLEN  instruction word
i_if_pc  in  XLEN  instruction PC
o_du_valid  out  1  decoded bundle valid to execute
i_ex_ready  in  1  execute accepts bundle
o_pc  out  XLEN  PC of bundle
o_opcode  out  7  instr[6:0]
o_funct3  out  3  instr[14:12]
o_funct7  out  7  instr[31:25]
o_immediate  out  XLEN  sign-extended immediate
o_rs1_rdata  out  XLEN  rs1 operand
o_rs2_rdata  out  XLEN  rs2 operand
o_rd_waddr  out  REG_AW  destination register
o_rd_wen  out  1  instruction writes rd (rd!=0)
o_illegal  out  1  unsupported opcode
o_rf_rs1_raddr  out  REG_AW  RF read address 1, combinational from i_if_instr
i_rf_rs1_rdata  in  XLEN  RF read data 1, combinational
o_rf_rs2_raddr  out  REG_AW  RF read address 2
i_rf_rs2_rdata  in  XLEN  RF read data 2
i_wb_valid  in  1  writeback strobe
i_wb_addr  in  REG_AW  writeback register
i_wb_data  in  XLEN  writeback data
i_flush  in  1  discard held bundle and block acceptance this cycle

Behaviour:
- Reset is clk and rstn: synchronous, active-low. During reset, all outputs registered by this block are 0 and the scoreboard is all 0.
- Field extraction: rs1 = instr[15+:REG_AW], rs2 = instr[20+:REG_AW], rd = instr[7+:REG_AW].
- hazard = i_if_valid AND (busy(rs1 if used) OR busy(rs2 if used) OR busy(rd if o_rd_wen-type)).
- busy(r) = sb[r] OR (o_du_valid AND o_rd_wen AND o_rd_waddr==r). Register r==0 is never busy.
- o_if_ready = (!o_du_valid OR i_ex_ready) AND !hazard AND !i_flush.
- accept = i_if_valid AND o_if_ready. On accept, the output register loads all decoded fields and o_du_valid=1 on the next cycle. Latency is 1 cycle.
- If o_du_valid AND !i_ex_ready, all outputs hold stable. The bundle is never dropped except by flush.
- Register x0 reads as 0 regardless of i_rf_*_rdata.
- Scoreboard set: on (o_du_valid AND i_ex_ready AND o_rd_wen), sb[o_rd_waddr] is set.
- Scoreboard clear: on i_wb_valid, sb[i_wb_addr] is cleared. If set and clear hit the same register in the same cycle, set wins.
- Flush: o_du_valid clears next cycle and no scoreboard bit is set for the flushed bundle. Existing scoreboard bits persist, because issued instructions still write back.
- Immediate formats:
  - I (LOAD, OP-IMM, JALR, SYSTEM): sext instr[31:20]
  - S: sext {31:25, 11:7}
  - B: sext {31, 7, 30:25, 11:8, 0}
  - U: {31:12, 12'b0}
  - J: sext {31, 19:12, 20, 30:21, 0}
  - R and MISC-MEM: 0
- Register usage:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - rd written by LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, with o_rd_wen = that AND rd!=0.
- o_illegal=1 if instr[1:0]!=2'b11 or the opcode is not in the RV32I set. In that case o_rd_wen=0 and the bundle still passes to execute for trap handling.

Optional Feature:
DECODE_WB_BYPASS_EN.
- Defined: if i_wb_valid AND i_wb_addr==rs (rs!=0), then sb[rs] is treated as clear for the hazard check and the operand captures i_wb_data instead of i_rf_*_rdata. This removes the one-cycle writeback stall.
- Undefined: no bypass. Decode stalls until the cycle after the writeback, and operands always come from the RF.

Decomposition:
- decode_pkg holds:
  - the opcode localparams (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, MISC_MEM 0001111, SYSTEM 1110011);
  - the enum imm_fmt_e {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J};
  - the decode_bundle_t struct.
- One combinational sub-module, decode_imm_gen, maps instruction and format to the immediate.

Test Plan:
- Reset mid-stream: rstn low for 1 cycle while o_du_valid=1 -> next cycle o_du_valid=0, all outputs 0, sb all 0, o_if_ready=1.
- Issue ADDI x5,x0,-1 (0xFFF00293), PC=0x100 -> one cycle later o_immediate=0xFFFFFFFF, o_rd_waddr=5, o_rd_wen=1, o_pc=0x100.
- Backpressure: hold i_ex_ready=0 for 3 cycles with a bundle held -> outputs stable, o_if_ready=0. On release, the next instruction is accepted in the same cycle.
- RAW hazard:
  - Stimulus: ADDI x5 issues, then ADD x6,x5,x5 is presented.
  - Response: o_if_ready=0 until i_wb_valid with addr 5 and data 0x1234.
  - With bypass: accept in the same cycle, operands 0x1234.
  - Without bypass: accept one cycle later.
- Flush during a held bundle with i_ex_ready=0 -> o_du_valid=0 next cycle, sb unchanged.
- Illegal instruction 0x00000000 -> o_illegal=1, o_rd_wen=0. B-type 0xFE000EE3 (BEQ x0,x0,-4) -> o_immediate=0xFFFFFFFC.
